mips_mc_control: RTL and testbench

- Multicycle MIPS main control FSM: decodes the 6-bit instruction opcode and sequences datapath control over several cycles.
- Produces the 2-bit alu_op that drives the ALU control decoder: 00 add, 01 subtract, 10 use funct field.
- Sits beside the multicycle datapath and drives all enables and muxes.
- Waits on a memory ready handshake for instruction and data accesses.

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/mips_mc_outdec.sv | 90 +++++++++
 rtl/mips_mc_control.sv | 102 ++++++++++
 tb/tb_mips_mc_control.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op codes,
// datapath mux selects, FSM states and the bundled control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Also consumed by the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic ALUA_PC  = 1'b0;
    localparam logic ALUA_REG = 1'b1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Pure state-to-control decode for the multicycle MIPS FSM; memory-completion
// qualified outputs are ANDed with mem_ready here.
module mips_mc_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            S_FETCH: begin
                // IR and PC load only on the completing cycle so a stalled
                // fetch never bumps the PC twice.
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = ALUA_PC;
                ctrl_o.alu_src_b = ALUB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = ALUA_PC;
                ctrl_o.alu_src_b = ALUB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = ALUA_REG;
                ctrl_o.alu_src_b = ALUB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.mem_write  = mem_ready_i;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = ALUA_REG;
                ctrl_o.alu_src_b = ALUB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = ALUA_REG;
                ctrl_o.alu_src_b     = ALUB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = ALUA_REG;
                ctrl_o.alu_src_b = ALUB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the datapath enables and mux selects.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q, state_d;
    logic       illegal_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_mem_op(opcode)) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (ENABLE_ADDI && opcode == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else begin
                    // Unsupported opcode: flag it and drop back to fetch with
                    // no architectural side effect.
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            // IR is stable here, so the opcode can be looked at again.
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_mc_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Reset masks every output combinationally so a pending store strobe
    // drops the instant rst rises, not at the next edge.
    assign pc_write      = ~rst & ctrl.pc_write;
    assign pc_write_cond = ~rst & ctrl.pc_write_cond;
    assign i_or_d        = ~rst & ctrl.i_or_d;
    assign mem_read      = ~rst & ctrl.mem_read;
    assign mem_write     = ~rst & ctrl.mem_write;
    assign ir_write      = ~rst & ctrl.ir_write;
    assign mem_to_reg    = ~rst & ctrl.mem_to_reg;
    assign pc_source     = rst ? 2'b00 : ctrl.pc_source;
    assign alu_op        = rst ? 2'b00 : ctrl.alu_op;
    assign alu_src_a     = ~rst & ctrl.alu_src_a;
    assign alu_src_b     = rst ? 2'b00 : ctrl.alu_src_b;
    assign reg_write     = ~rst & ctrl.reg_write;
    assign reg_dst       = ~rst & ctrl.reg_dst;
    assign instr_done    = ~rst & ctrl.instr_done;
    assign illegal_op    = ~rst & illegal_d;
    assign state         = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed table-driven bench for mips_mc_control plus hand sequences for
// asynchronous reset and the addi-disabled build.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       mem_ready = 1'b1;
    logic [5:0] opcode2 = 6'b000000;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, instr_done, illegal_op;
    logic [3:0] state;

    logic       pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2, mem_to_reg2;
    logic [1:0] pc_source2, alu_op2, alu_src_b2;
    logic       alu_src_a2, reg_write2, reg_dst2, instr_done2, illegal_op2;
    logic [3:0] state2;

    always #5 clk = ~clk;

    mips_mc_control #(.ENABLE_ADDI(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .reg_dst(reg_dst), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    mips_mc_control #(.ENABLE_ADDI(1'b0)) dut_noaddi (
        .clk(clk), .rst(rst), .opcode(opcode2), .mem_ready(1'b1),
        .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .i_or_d(i_or_d2),
        .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
        .mem_to_reg(mem_to_reg2), .pc_source(pc_source2), .alu_op(alu_op2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .reg_write(reg_write2),
        .reg_dst(reg_dst2), .instr_done(instr_done2), .illegal_op(illegal_op2),
        .state(state2)
    );

    // {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcsrc[2], aluop[2], srca, srcb[2], rw, rdst, done, ill}
    logic [17:0] outs, outs2;
    assign outs  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                    pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, instr_done, illegal_op};
    assign outs2 = {pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2, mem_to_reg2,
                    pc_source2, alu_op2, alu_src_a2, alu_src_b2, reg_write2, reg_dst2, instr_done2,
                    illegal_op2};

    localparam logic [17:0] O_ZERO   = 18'd0;
    //                                  pcw  pcwc iord mrd  mwr  irw  m2r  pcs    aop    sa   sb     rw   rd   dn   il
    localparam logic [17:0] O_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_FSTALL = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0,1'b1};
    localparam logic [17:0] O_MADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_MRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0};
    localparam logic [17:0] O_MWR    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0};
    localparam logic [17:0] O_MWRST  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b1,1'b1,1'b0};
    localparam logic [17:0] O_BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b1,2'b00,1'b0,1'b0,1'b1,1'b0};
    localparam logic [17:0] O_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0};
    localparam logic [17:0] O_AEX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] O_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st, input logic [17:0] o);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.out = o;
        vecs.push_back(v);
    endtask

    task automatic step_to(input logic [5:0] op, input logic rdy);
        opcode = op; mem_ready = rdy;
        @(posedge clk); #1;
    endtask

    initial begin
        // lw, ready throughout: 0,1,2,3,4
        add(LW,1,0,O_FETCH); add(LW,1,1,O_DEC); add(LW,1,2,O_MADR); add(LW,1,3,O_MRD); add(LW,1,4,O_MWB);
        // sw with two stall cycles in MEMWR
        add(SW,1,0,O_FETCH); add(SW,1,1,O_DEC); add(SW,1,2,O_MADR);
        add(SW,0,5,O_MWRST); add(SW,0,5,O_MWRST); add(SW,1,5,O_MWR);
        // R-type after a stalled fetch; opcode garbage in EXEC is ignored
        add(RT,0,0,O_FSTALL); add(RT,1,0,O_FETCH); add(RT,1,1,O_DEC); add(BAD,1,6,O_EXEC); add(BAD,1,7,O_ALUWB);
        // lw with one stall in MEMRD
        add(LW,1,0,O_FETCH); add(LW,1,1,O_DEC); add(LW,1,2,O_MADR); add(LW,0,3,O_MRD); add(LW,1,3,O_MRD);
        add(LW,1,4,O_MWB);
        // beq then j
        add(BQ,1,0,O_FETCH); add(BQ,1,1,O_DEC); add(BQ,1,8,O_BR);
        add(JJ,1,0,O_FETCH); add(JJ,1,1,O_DEC); add(JJ,1,9,O_JMP);
        // illegal opcode, then addi
        add(BAD,1,0,O_FETCH); add(BAD,1,1,O_DECILL);
        add(AI,1,0,O_FETCH); add(AI,1,1,O_DEC); add(AI,1,10,O_AEX); add(AI,1,11,O_AWB);
        add(LW,0,0,O_FSTALL);

        // reset state
        #2;
        chk("reset_state", {14'd0, state}, 18'd0);
        chk("reset_outs", outs, O_ZERO);
        chk("reset_outs_noaddi", outs2, O_ZERO);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].op; mem_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), {14'd0, state}, {14'd0, vecs[i].st});
            chk($sformatf("vec%0d_outs", i), outs, vecs[i].out);
            @(posedge clk); #1;
        end

        // Reset asserted mid-MEMRD with memory stalled: async clear, no edge needed.
        step_to(LW, 1); step_to(LW, 1); step_to(LW, 0);
        @(negedge clk);
        chk("pre_rst_memrd", {14'd0, state}, 18'd3);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_state", {14'd0, state}, 18'd0);
        chk("async_rst_outs", outs, O_ZERO);

        // Reset asserted while a store strobe is high.
        @(posedge clk); #1;
        rst = 1'b0; opcode2 = AI;
        step_to(SW, 1); step_to(SW, 1); step_to(SW, 1);
        opcode = SW; mem_ready = 1'b1;
        #1;
        chk("pre_rst_memwr", outs, O_MWR);
        rst = 1'b1;
        #1;
        chk("rst_drops_mem_write", outs, O_ZERO);
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; opcode = LW;
        @(negedge clk);
        chk("post_rst_fetch", outs, O_FETCH);
        chk("noaddi_fetch_state", {14'd0, state2}, 18'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("noaddi_decode_state", {14'd0, state2}, 18'd1);
        chk("noaddi_illegal", outs2, O_DECILL);
        @(posedge clk); #1;
        @(negedge clk);
        chk("noaddi_back_to_fetch", {14'd0, state2}, 18'd0);
        chk("noaddi_fetch_outs", outs2, O_FETCH);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
